// File: rtl/neuron_argmax_if.sv
// Score-in / argmax-result-out handshake bundle for neuron_argmax.
// slave is the argmax block's view; master is the producer/consumer side.
interface neuron_argmax_if #(
  parameter int unsigned N_CLASS = 4,
  parameter int unsigned WIDTH   = 8
);
  localparam int unsigned SW = 2 * WIDTH + 2;
  localparam int unsigned IW = $clog2(N_CLASS);

  logic                 in_valid;
  logic                 in_ready;
  logic signed [SW-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [IW-1:0]        out_index;
  logic signed [SW-1:0] out_score;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_index, out_score
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_index, out_score
  );
endinterface

// File: rtl/neuron_argmax.sv
// Streaming argmax over frames of N_CLASS signed neuron scores.
// Define NEURON_ARGMAX_TIE_LAST_EN to let the highest index win ties (default: lowest).
module neuron_argmax #(
  parameter int unsigned N_CLASS = 4,
  parameter int unsigned WIDTH   = 8
) (
  input  logic           clk,
  input  logic           rst,
  neuron_argmax_if.slave io
);
  localparam int unsigned SW = 2 * WIDTH + 2;
  localparam int unsigned IW = $clog2(N_CLASS);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_CLASS - 1);

  typedef enum logic {
    S_COLLECT = 1'b0,
    S_HOLD    = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [IW-1:0]        cnt_q, cnt_d;
  logic signed [SW-1:0] best_score_q, best_score_d;
  logic [IW-1:0]        best_index_q, best_index_d;
  logic signed [SW-1:0] out_score_q, out_score_d;
  logic [IW-1:0]        out_index_q, out_index_d;
  logic                 beats_best;

  // Tie rule: strict compare keeps the earliest maximum, >= moves to the latest.
`ifdef NEURON_ARGMAX_TIE_LAST_EN
  assign beats_best = (io.in_data >= best_score_q);
`else
  assign beats_best = (io.in_data > best_score_q);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_COLLECT;
      cnt_q        <= '0;
      best_score_q <= '0;
      best_index_q <= '0;
      out_score_q  <= '0;
      out_index_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      best_score_q <= best_score_d;
      best_index_q <= best_index_d;
      out_score_q  <= out_score_d;
      out_index_q  <= out_index_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    best_score_d = best_score_q;
    best_index_d = best_index_q;
    out_score_d  = out_score_q;
    out_index_d  = out_index_q;

    case (state_q)
      S_COLLECT: begin
        if (io.in_valid) begin
          cnt_d = cnt_q + IW'(1);
          // First score of a frame seeds the running best unconditionally.
          if ((cnt_q == '0) || beats_best) begin
            best_score_d = io.in_data;
            best_index_d = cnt_q;
          end
          if (cnt_q == LAST_IDX) begin
            state_d     = S_HOLD;
            cnt_d       = '0;
            out_score_d = best_score_d;
            out_index_d = best_index_d;
          end
        end
      end
      S_HOLD: begin
        if (io.out_ready) begin
          state_d = S_COLLECT;
        end
      end
      default: begin
        state_d = S_COLLECT;
      end
    endcase
  end

  // Handshake flags come from state only; rst masks ready while held in reset.
  assign io.in_ready  = (state_q == S_COLLECT) && !rst;
  assign io.out_valid = (state_q == S_HOLD);
  assign io.out_index = out_index_q;
  assign io.out_score = out_score_q;

  a_ready_valid_excl : assert property (@(posedge clk) !(io.in_ready && io.out_valid));

  a_hold_stable : assert property (@(posedge clk) disable iff (rst)
    (io.out_valid && !io.out_ready) |=>
      (io.out_valid && $stable(io.out_index) && $stable(io.out_score)));

endmodule

// File: tb/tb_neuron_argmax.sv
// Self-checking bench for neuron_argmax (N_CLASS=4, WIDTH=8): directed frames plus
// randomly throttled traffic checked against a reference argmax.
module tb_neuron_argmax;
  localparam int unsigned N     = 4;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned SW    = 2 * WIDTH + 2;
  localparam int unsigned IW    = $clog2(N);

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  neuron_argmax_if #(.N_CLASS(N), .WIDTH(WIDTH)) io ();

  neuron_argmax #(.N_CLASS(N), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io.slave)
  );

  // Reference: find the maximum value, then pick its first (or last) occurrence.
  function automatic void ref_argmax(input logic signed [SW-1:0] s [N],
                                     output logic [IW-1:0] idx,
                                     output logic signed [SW-1:0] mx);
    mx = s[0];
    for (int i = 1; i < N; i++) if (s[i] > mx) mx = s[i];
    idx = '0;
`ifdef NEURON_ARGMAX_TIE_LAST_EN
    for (int i = 0; i < N; i++) if (s[i] == mx) idx = IW'(i);
`else
    for (int i = N - 1; i >= 0; i--) if (s[i] == mx) idx = IW'(i);
`endif
  endfunction

  // One clock: drive inputs, record what the DUT presents during this cycle, advance.
  task automatic cycle(input logic v, input logic signed [SW-1:0] d, input logic ordy,
                       output logic acc, output logic ov, output logic [IW-1:0] oi,
                       output logic signed [SW-1:0] os);
    io.in_valid  = v;
    io.in_data   = d;
    io.out_ready = ordy;
    #1;
    acc = v && io.in_ready;
    ov  = io.out_valid;
    oi  = io.out_index;
    os  = io.out_score;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int s0, input int s1, input int s2, input int s3,
                            input int eidx, input int escr, input string name);
    int                   s [N];
    logic                 acc, ov;
    logic [IW-1:0]        oi;
    logic signed [SW-1:0] os, exp_s;
    s = '{s0, s1, s2, s3};
    for (int i = 0; i < N; i++) begin
      cycle(1'b1, SW'(s[i]), 1'b0, acc, ov, oi, os);
      n_checks++;
      if (acc !== 1'b1 || ov !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_accept%0d: accepted=%b out_valid=%b, required accepted=1 out_valid=0",
                 name, i, acc, ov);
      end
    end
    io.in_valid = 1'b0;
    exp_s = SW'(escr);
    n_checks++;
    if (io.out_valid !== 1'b1 || io.out_index !== IW'(eidx) || io.out_score !== exp_s) begin
      n_fail++;
      $display("FAIL %s_result: valid=%b index=%0d score=%0d, required valid=1 index=%0d score=%0d",
               name, io.out_valid, io.out_index, io.out_score, eidx, exp_s);
    end
  endtask

  task automatic release_result(input string name);
    logic                 acc, ov;
    logic [IW-1:0]        oi;
    logic signed [SW-1:0] os;
    cycle(1'b0, '0, 1'b1, acc, ov, oi, os);
    io.out_ready = 1'b0;
    n_checks++;
    if (io.out_valid !== 1'b0 || io.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_release: out_valid=%b in_ready=%b, required out_valid=0 in_ready=1",
               name, io.out_valid, io.in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    io.in_valid = 1'b0; io.in_data = '0; io.out_ready = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (io.in_ready !== 1'b0 || io.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold: in_ready=%b out_valid=%b, required 0 0", io.in_ready, io.out_valid);
      end
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (io.in_ready !== 1'b1 || io.out_valid !== 1'b0 || io.out_index !== '0 || io.out_score !== '0) begin
      n_fail++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b index=%0d score=%0d, required 1 0 0 0",
               io.in_ready, io.out_valid, io.out_index, io.out_score);
    end
  endtask

  task automatic test_back_to_back();
    send_frame(5, 20, 7, 3, 1, 20, "b2b");
    release_result("b2b");
  endtask

  task automatic test_ties();
    int eidx;
`ifdef NEURON_ARGMAX_TIE_LAST_EN
    eidx = 3;
`else
    eidx = 0;
`endif
    send_frame(9, 9, 2, 9, eidx, 9, "tie");
    release_result("tie");
  endtask

  task automatic test_signed();
    send_frame(0, 0, 0, 0, 0, 0, "zero");
    release_result("zero");
    send_frame(-5, -2, -9, -3, 1, -2, "neg");
    release_result("neg");
    send_frame(-131072, 131071, 131070, -1, 1, 131071, "extreme");
    release_result("extreme");
  endtask

  task automatic test_hold();
    logic                 acc, ov;
    logic [IW-1:0]        oi;
    logic signed [SW-1:0] os;
    send_frame(5, 20, 7, 3, 1, 20, "hold_pre");
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, SW'(99), 1'b0, acc, ov, oi, os);
      n_checks++;
      if (acc !== 1'b0 || ov !== 1'b1 || oi !== IW'(1) || os !== SW'(20)) begin
        n_fail++;
        $display("FAIL hold_stall%0d: accepted=%b valid=%b index=%0d score=%0d, required 0 1 1 20",
                 i, acc, ov, oi, os);
      end
    end
    io.in_valid = 1'b0;
    release_result("hold");
    send_frame(1, 2, 3, 4, 3, 4, "hold_next");
    release_result("hold_next");
  endtask

  task automatic test_reset_mid();
    logic                 acc, ov;
    logic [IW-1:0]        oi;
    logic signed [SW-1:0] os;
    cycle(1'b1, SW'(30), 1'b0, acc, ov, oi, os);
    cycle(1'b1, SW'(40), 1'b0, acc, ov, oi, os);
    rst = 1'b1;
    io.in_valid = 1'b1;
    io.in_data  = SW'(77);
    @(posedge clk);
    #1;
    n_checks++;
    if (io.in_ready !== 1'b0 || io.out_valid !== 1'b0 || io.out_index !== '0 || io.out_score !== '0) begin
      n_fail++;
      $display("FAIL midrst_state: in_ready=%b out_valid=%b index=%0d score=%0d, required 0 0 0 0",
               io.in_ready, io.out_valid, io.out_index, io.out_score);
    end
    rst = 1'b0;
    io.in_valid = 1'b0;
    send_frame(1, 50, 2, 3, 1, 50, "post_rst");
    release_result("post_rst");
  endtask

  task automatic test_random();
    logic signed [SW-1:0] cur [N];
    int                   n_cur = 0;
    logic [IW-1:0]        exp_idx_q [$];
    logic signed [SW-1:0] exp_scr_q [$];
    logic [IW-1:0]        ridx, pidx, e_i;
    logic signed [SW-1:0] rscr, pscr, e_s, d;
    logic                 v, ordy, acc, ov, stalled;
    logic [IW-1:0]        oi;
    logic signed [SW-1:0] os;
    int                   frames = 0;
    int                   cyc = 0;
    stalled = 1'b0; pidx = '0; pscr = '0;
    while (frames < 1000 && cyc < 60000) begin
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 1) == 1) d = SW'(int'($urandom_range(0, 6)) - 3);
      else                           d = SW'($urandom);
      cycle(v, d, ordy, acc, ov, oi, os);
      cyc++;
      if (stalled) begin
        n_checks++;
        if (ov !== 1'b1 || oi !== pidx || os !== pscr) begin
          n_fail++;
          $display("FAIL rand_stable: valid=%b index=%0d score=%0d, required 1 %0d %0d",
                   ov, oi, os, pidx, pscr);
        end
      end
      stalled = ov && !ordy;
      pidx = oi; pscr = os;
      if (acc) begin
        cur[n_cur] = d;
        n_cur++;
        if (n_cur == N) begin
          ref_argmax(cur, ridx, rscr);
          exp_idx_q.push_back(ridx);
          exp_scr_q.push_back(rscr);
          n_cur = 0;
        end
      end
      if (ov && ordy) begin
        frames++;
        n_checks++;
        if (exp_idx_q.size() == 0) begin
          n_fail++;
          $display("FAIL rand_spurious: result index=%0d score=%0d, required no result", oi, os);
        end else begin
          e_i = exp_idx_q.pop_front();
          e_s = exp_scr_q.pop_front();
          if (oi !== e_i || os !== e_s) begin
            n_fail++;
            $display("FAIL rand_frame%0d: index=%0d score=%0d, required index=%0d score=%0d",
                     frames, oi, os, e_i, e_s);
          end
        end
      end
    end
    io.in_valid = 1'b0; io.out_ready = 1'b0;
    n_checks++;
    if (frames != 1000 || exp_idx_q.size() != 0) begin
      n_fail++;
      $display("FAIL rand_count: frames=%0d pending=%0d, required frames=1000 pending=0",
               frames, exp_idx_q.size());
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time exhausted, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_ties();
    test_signed();
    test_hold();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/neuron_argmax.md
NEURON_ARGMAX -- requirements
Module: neuron_argmax

Interface
REQ-001 Parameter N_CLASS, default 4: neuron outputs per frame, legal range 2..256.
REQ-002 Parameter WIDTH, default 8: neuron operand width; score width SW = 2*WIDTH+2 (18 by default).
REQ-003 Localparam IW = $clog2(N_CLASS): index width.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  one clock; reset is synchronous and active-high.
REQ-006 in_valid  input  1  upstream neuron score valid.
REQ-007 in_ready  output  1  block accepts a score this cycle.
REQ-008 in_data  input  SW signed  neuron score (ReLU output y).
REQ-009 out_valid  output  1  frame result valid.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 out_index  output  IW  position in the frame (0..N_CLASS-1) of the winning score.
REQ-012 out_score  output  SW signed  winning score value.

Function
REQ-013 Transfer occurs on a cycle where valid and ready are both 1 (in_*, out_*); no other cycle changes frame state.
REQ-014 FSM has two states: COLLECT (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-015 Frame counter cnt (IW bits) counts accepted scores: 0 at frame start, +1 per accept in COLLECT.
REQ-016 Accept with cnt==0: best_score <= in_data and best_index <= 0, unconditionally.
REQ-017 Accept with cnt>0: if in_data > best_score (signed compare, full SW bits, no truncation), best_score <= in_data and best_index <= cnt; otherwise hold.
REQ-018 Accept with cnt==N_CLASS-1: apply REQ-016/017, then go to HOLD and cnt <= 0 on the same edge.
REQ-019 Latency: out_valid=1 the cycle after the N_CLASS-th accept; out_index/out_score present the final best values in that cycle.
REQ-020 In HOLD, out_valid, out_index and out_score stay stable until out_ready=1; in_valid is ignored (no accept, no loss of held result).
REQ-021 HOLD with out_ready=1: go to COLLECT next cycle; a new frame's first score can be accepted that next cycle (one bubble per frame).
REQ-022 out_index/out_score are registered and keep their last values in COLLECT; only out_valid qualifies them.
REQ-023 in_ready and out_valid are decoded from the state register only, with no combinational path from in_valid/out_ready.

Reset
REQ-024 rst=1 at a clock edge: state <= COLLECT, cnt <= 0, best_score <= 0, best_index <= 0, overriding any simultaneous transfer.
REQ-025 While rst=1: in_ready=0 and out_valid=0; after release: in_ready=1 and out_valid=0, out_index=0 and out_score=0.
REQ-026 rst mid-frame or during HOLD discards the partial frame or held result; the next accepted score starts a new frame at cnt=0.

Configuration
REQ-027 Macro NEURON_ARGMAX_TIE_LAST_EN selects the tie rule.
REQ-028 Without the macro: strict > compare; on equal scores the lowest index wins.
REQ-029 With the macro: >= compare in REQ-017; on equal scores the highest index wins; all other behaviour is identical.

Verification (N_CLASS=4, WIDTH=8)
REQ-030 Scores 5,20,7,3 on back-to-back cycles -> out_valid=1 one cycle after the 4th accept, out_index=1, out_score=20.
REQ-031 Scores 9,9,2,9 -> out_index=0 without NEURON_ARGMAX_TIE_LAST_EN, out_index=3 with it; out_score=9 in both cases.
REQ-032 All-zero frame 0,0,0,0 -> out_index=0, out_score=0; signed frame -5,-2,-9,-3 -> out_index=1, out_score=-2.
REQ-033 out_ready=0 for 5 cycles in HOLD while in_valid=1 with data 99 -> result stays constant, in_ready=0, no score is accepted; on out_ready=1 the next frame 1,2,3,4 gives index 3, score 4.
REQ-034 rst pulse after 2 accepts (30,40) -> outputs return to reset values; the next frame 1,50,2,3 gives index 1, score 50.
REQ-035 Random valid/ready throttling over 1000 frames -> every result matches a reference argmax, with no dropped or duplicated scores.
